// File: rtl/cuckoo_match_engine.sv
// Cuckoo lookup stage: per channel, two pre-hashed bucket indices select two
// candidate pattern entries that are compared against the aligned payload
// window. Four register stages, a shared advance/stall, runtime-programmable
// tables and saturating per-channel hit counters.
module cuckoo_match_engine #(
  parameter int PAT_BYTES = 14,
  parameter int HASH_W    = 10,
  parameter int IDX_W     = 9,
  parameter int SUFFIX_W  = 2,
  parameter int NUM_CH    = 2,
  parameter int WIN_W     = 160,
  parameter int CNT_W     = 32,
  localparam int PAT_W    = 8 * PAT_BYTES,
  localparam int ENT_W    = PAT_W + SUFFIX_W + 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*HASH_W-1:0]     preHash_T1,
  input  logic [NUM_CH*HASH_W-1:0]     preHash_T2,
  input  logic [NUM_CH*WIN_W-1:0]      win_in,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic                         cfg_sel,
  input  logic [HASH_W:0]              cfg_addr,
  input  logic [ENT_W-1:0]             cfg_wdata,
  output logic                         out_valid,
  output logic [NUM_CH*2-1:0]          compare_out,
  output logic [NUM_CH*SUFFIX_W-1:0]   suffix,
  output logic [NUM_CH*IDX_W-1:0]      match_idx,
  input  logic                         cnt_clr,
  output logic [NUM_CH*CNT_W-1:0]      hit_cnt
);

  // Index table holds T1 in the lower half and T2 in the upper half.
  logic [IDX_W-1:0] idx_mem [NUM_CH][2**(HASH_W+1)];
  logic [ENT_W-1:0] ent_mem [NUM_CH][2**IDX_W];

  logic adv;
  assign adv      = enable & ~cfg_we;
  assign in_ready = adv;

  // S1: bucket addresses and the pattern-aligned window slice
  logic                                v1_q, v1_d;
  logic [NUM_CH-1:0][HASH_W-1:0]       a1_q, a1_d, a2_q, a2_d;
  logic [NUM_CH-1:0][PAT_W-1:0]        w1_q, w1_d;
  // S2: index-table read data
  logic                                v2_q, v2_d;
  logic [NUM_CH-1:0][IDX_W-1:0]        ia_q, ia_d, ib_q, ib_d;
  logic [NUM_CH-1:0][PAT_W-1:0]        w2_q, w2_d;
  // S3: entry-table read data with indices kept alongside
  logic                                v3_q, v3_d;
  logic [NUM_CH-1:0][ENT_W-1:0]        ea_q, ea_d, eb_q, eb_d;
  logic [NUM_CH-1:0][IDX_W-1:0]        ia3_q, ia3_d, ib3_q, ib3_d;
  logic [NUM_CH-1:0][PAT_W-1:0]        w3_q, w3_d;
  // S4: registered results and counters
  logic                                ov_q, ov_d;
  logic [NUM_CH-1:0][1:0]              cmp_q, cmp_d;
  logic [NUM_CH-1:0][SUFFIX_W-1:0]     suf_q, suf_d;
  logic [NUM_CH-1:0][IDX_W-1:0]        mid_q, mid_d;
  logic [NUM_CH-1:0][CNT_W-1:0]        cnt_q, cnt_d;

  logic [NUM_CH-1:0] hit_a, hit_b;

  // Only bytes [7:0] and the pattern slice of each window are consumed.
  logic unused_win;
  assign unused_win = ^win_in;

  function automatic logic [HASH_W-1:0] hash_f(input logic [HASH_W-1:0] p,
                                               input logic [7:0] b);
    return (({p[HASH_W-4:0], 3'b000} + {3'b000, p[HASH_W-1:3]} + HASH_W'(b)) ^ p);
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_hit
    assign hit_a[g] = v3_q & ea_q[g][ENT_W-1] & (ea_q[g][PAT_W-1:0] == w3_q[g]);
    assign hit_b[g] = v3_q & eb_q[g][ENT_W-1] & (eb_q[g][PAT_W-1:0] == w3_q[g]);
  end

  // Table programming; contents survive reset, writes to absent channels drop.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_we && (cfg_ch == CH_W'(c))) begin
        if (!cfg_sel) idx_mem[c][cfg_addr] <= cfg_wdata[IDX_W-1:0];
        else          ent_mem[c][cfg_addr[IDX_W-1:0]] <= cfg_wdata;
      end
    end
  end

  // Next-state for all pipeline stages; everything holds while adv is low.
  always_comb begin
    v1_d = v1_q;  a1_d = a1_q;  a2_d = a2_q;  w1_d = w1_q;
    v2_d = v2_q;  ia_d = ia_q;  ib_d = ib_q;  w2_d = w2_q;
    v3_d = v3_q;  ea_d = ea_q;  eb_d = eb_q;  ia3_d = ia3_q; ib3_d = ib3_q; w3_d = w3_q;
    ov_d = ov_q;  cmp_d = cmp_q; suf_d = suf_q; mid_d = mid_q;
    cnt_d = cnt_q;
    if (adv) begin
      v1_d = in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
      ov_d = v3_q;
      for (int c = 0; c < NUM_CH; c++) begin
        a1_d[c]  = hash_f(preHash_T1[c*HASH_W +: HASH_W], win_in[c*WIN_W +: 8]);
        a2_d[c]  = hash_f(preHash_T2[c*HASH_W +: HASH_W], win_in[c*WIN_W +: 8]);
        w1_d[c]  = win_in[c*WIN_W + 32 +: PAT_W];
        ia_d[c]  = idx_mem[c][{1'b0, a1_q[c]}];
        ib_d[c]  = idx_mem[c][{1'b1, a2_q[c]}];
        w2_d[c]  = w1_q[c];
        ea_d[c]  = ent_mem[c][ia_q[c]];
        eb_d[c]  = ent_mem[c][ib_q[c]];
        ia3_d[c] = ia_q[c];
        ib3_d[c] = ib_q[c];
        w3_d[c]  = w2_q[c];
        cmp_d[c] = {hit_b[c], hit_a[c]};
        if (hit_a[c]) begin
          suf_d[c] = ea_q[c][PAT_W +: SUFFIX_W];
          mid_d[c] = ia3_q[c];
        end else if (hit_b[c]) begin
          suf_d[c] = eb_q[c][PAT_W +: SUFFIX_W];
          mid_d[c] = ib3_q[c];
        end else begin
          suf_d[c] = '0;
          mid_d[c] = '0;
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (cnt_clr)
        cnt_d[c] = '0;
      else if (adv && ov_q && (|cmp_q[c]) && !(&cnt_q[c]))
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
    end
  end

  // Pipeline, output and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0; a1_q <= '0; a2_q <= '0; w1_q <= '0;
      v2_q <= 1'b0; ia_q <= '0; ib_q <= '0; w2_q <= '0;
      v3_q <= 1'b0; ea_q <= '0; eb_q <= '0; ia3_q <= '0; ib3_q <= '0; w3_q <= '0;
      ov_q <= 1'b0; cmp_q <= '0; suf_q <= '0; mid_q <= '0;
      cnt_q <= '0;
    end else begin
      v1_q <= v1_d; a1_q <= a1_d; a2_q <= a2_d; w1_q <= w1_d;
      v2_q <= v2_d; ia_q <= ia_d; ib_q <= ib_d; w2_q <= w2_d;
      v3_q <= v3_d; ea_q <= ea_d; eb_q <= eb_d; ia3_q <= ia3_d; ib3_q <= ib3_d; w3_q <= w3_d;
      ov_q <= ov_d; cmp_q <= cmp_d; suf_q <= suf_d; mid_q <= mid_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid   = ov_q;
  assign compare_out = cmp_q;
  assign suffix      = suf_q;
  assign match_idx   = mid_q;
  assign hit_cnt     = cnt_q;

endmodule

// File: tb/tb_cuckoo_match_engine.sv
// Bench for cuckoo_match_engine: reference tables plus a result-level model
// (four-stage result delay, saturating counters) checked every cycle.
module tb_cuckoo_match_engine;
  localparam int HW = 10, IW = 9, SW = 2, NC = 2, WW = 160, CW = 4;
  localparam int PW = 112, EW = PW + SW + 1;

  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, in_valid = 1'b0;
  logic cfg_we = 1'b0, cfg_sel = 1'b0, cnt_clr = 1'b0;
  logic [0:0] cfg_ch = '0;
  logic [HW:0] cfg_addr = '0;
  logic [EW-1:0] cfg_wdata = '0;
  logic [HW-1:0] d_pre1 [NC], d_pre2 [NC];
  logic [WW-1:0] d_win [NC];
  logic [NC*HW-1:0] preHash_T1, preHash_T2;
  logic [NC*WW-1:0] win_in;
  logic in_ready, out_valid;
  logic [NC*2-1:0] compare_out;
  logic [NC*SW-1:0] suffix;
  logic [NC*IW-1:0] match_idx;
  logic [NC*CW-1:0] hit_cnt;

  assign preHash_T1 = {d_pre1[1], d_pre1[0]};
  assign preHash_T2 = {d_pre2[1], d_pre2[0]};
  assign win_in     = {d_win[1], d_win[0]};

  always #5 clk = ~clk;

  cuckoo_match_engine #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .preHash_T1(preHash_T1), .preHash_T2(preHash_T2), .win_in(win_in),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .out_valid(out_valid), .compare_out(compare_out),
    .suffix(suffix), .match_idx(match_idx), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt));

  typedef struct packed {
    logic                   v;
    logic [NC-1:0][1:0]     cmp;
    logic [NC-1:0][SW-1:0]  suf;
    logic [NC-1:0][IW-1:0]  idx;
  } res_t;

  logic [IW-1:0] m_idx [NC][2048];
  logic          m_v   [NC][512];
  logic [SW-1:0] m_suf [NC][512];
  logic [PW-1:0] m_pat [NC][512];
  res_t          sr [4];
  logic [CW-1:0] e_cnt [NC];
  int total = 0, bad = 0;
  logic [PW-1:0] pat_a, pat_b;

  function automatic int hash_m(int pre, int b);
    return (((pre * 8) + (pre / 8) + b) % 1024) ^ pre;
  endfunction

  function automatic res_t predict();
    res_t r;
    r = '0;
    if (!in_valid) return r;
    r.v = 1'b1;
    for (int c = 0; c < NC; c++) begin
      int a1, a2;
      logic [IW-1:0] ia, ib;
      logic ha, hb;
      a1 = hash_m(int'(d_pre1[c]), int'(d_win[c][7:0]));
      a2 = hash_m(int'(d_pre2[c]), int'(d_win[c][7:0]));
      ia = m_idx[c][a1];
      ib = m_idx[c][1024 + a2];
      ha = m_v[c][ia] && (m_pat[c][ia] == d_win[c][143:32]);
      hb = m_v[c][ib] && (m_pat[c][ib] == d_win[c][143:32]);
      r.cmp[c] = {hb, ha};
      if (ha) begin r.suf[c] = m_suf[c][ia]; r.idx[c] = ia; end
      else if (hb) begin r.suf[c] = m_suf[c][ib]; r.idx[c] = ib; end
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] mk_win(input logic [PW-1:0] pat, input logic [7:0] b);
    return {16'($urandom), pat, 24'($urandom), b};
  endfunction

  function automatic logic [PW-1:0] rnd_pat();
    return PW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // One clock: the model consumes the same inputs the DUT sees at this edge.
  task automatic tick();
    logic adv_m;
    res_t nr;
    adv_m = enable && !cfg_we;
    nr = predict();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 4; i++) sr[i] = '0;
      for (int c = 0; c < NC; c++) e_cnt[c] = '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (cnt_clr) e_cnt[c] = '0;
        else if (adv_m && sr[3].v && sr[3].cmp[c] != 2'b00 && e_cnt[c] != '1) e_cnt[c]++;
      end
      if (cfg_we) begin
        if (!cfg_sel) m_idx[cfg_ch][cfg_addr] = cfg_wdata[IW-1:0];
        else begin
          m_v[cfg_ch][cfg_addr[IW-1:0]]   = cfg_wdata[EW-1];
          m_suf[cfg_ch][cfg_addr[IW-1:0]] = cfg_wdata[PW +: SW];
          m_pat[cfg_ch][cfg_addr[IW-1:0]] = cfg_wdata[PW-1:0];
        end
      end
      if (adv_m) begin
        sr[3] = sr[2]; sr[2] = sr[1]; sr[1] = sr[0]; sr[0] = nr;
      end
    end
    #1;
  endtask

  task automatic cfg_write(input int ch, input logic sel, input int addr, input logic [EW-1:0] data);
    cfg_ch = 1'(ch); cfg_sel = sel; cfg_addr = (HW+1)'(addr); cfg_wdata = data;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_win(input int c, input logic [HW-1:0] p1, input logic [HW-1:0] p2, input logic [WW-1:0] w);
    d_pre1[c] = p1; d_pre2[c] = p2; d_win[c] = w;
  endtask

  task automatic rnd_ch1();
    set_win(1, 10'($urandom), 10'($urandom), mk_win(rnd_pat(), 8'($urandom)));
  endtask

  task automatic clear_tables();
    for (int c = 0; c < NC; c++) begin
      for (int a = 0; a < 2048; a++) cfg_write(c, 1'b0, a, '0);
      for (int a = 0; a < 512; a++) cfg_write(c, 1'b1, a, '0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1; in_valid = 1'b0;
    #1;
    total++;
    if ({out_valid, compare_out, suffix, match_idx, hit_cnt} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {out_valid, compare_out, suffix, match_idx, hit_cnt});
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    cfg_we = 1'b1; #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_we got=%b exp=0", in_ready); end
    cfg_we = 1'b0;
    #10 rst = 1'b1;
  endtask

  task automatic test_basic();
    cfg_write(0, 1'b0, 'h05A, 3);
    cfg_write(0, 1'b1, 3, {1'b1, 2'b10, pat_a});
    enable = 1'b1;
    set_win(0, '0, '0, mk_win(pat_a, 8'h5A)); rnd_ch1();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      in_valid = 1'b0;
      total++;
      if ({out_valid, compare_out, suffix, match_idx, hit_cnt} !== {sr[3], e_cnt[1], e_cnt[0]}) begin
        bad++; $display("FAIL basic t%0d got=%h exp=%h", i, {out_valid, compare_out, suffix, match_idx, hit_cnt}, {sr[3], e_cnt[1], e_cnt[0]});
      end
      if (i == 3) begin
        total++;
        if (out_valid !== 1'b1 || compare_out[1:0] !== 2'b01 || suffix[1:0] !== 2'b10 || match_idx[8:0] !== 9'd3) begin
          bad++; $display("FAIL basic_hit got v=%b c=%b s=%b i=%0d exp v=1 c=01 s=10 i=3", out_valid, compare_out[1:0], suffix[1:0], match_idx[8:0]);
        end
      end
    end
    total++;
    if (hit_cnt[3:0] !== 4'd1) begin bad++; $display("FAIL basic_cnt got=%0d exp=1", hit_cnt[3:0]); end
  endtask

  task automatic test_dual();
    cfg_write(0, 1'b0, 'h45A, 7);
    cfg_write(0, 1'b1, 7, {1'b1, 2'b01, pat_a});
    cfg_write(0, 1'b0, 'h011, 9);
    cfg_write(0, 1'b1, 9, {1'b0, 2'b11, pat_b});
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 2);
      if (i == 0) set_win(0, '0, '0, mk_win(pat_a, 8'h5A));
      if (i == 1) set_win(0, '0, '0, mk_win(pat_b, 8'h11));
      rnd_ch1();
      tick();
      total++;
      if ({out_valid, compare_out, suffix, match_idx, hit_cnt} !== {sr[3], e_cnt[1], e_cnt[0]}) begin
        bad++; $display("FAIL dual t%0d got=%h exp=%h", i, {out_valid, compare_out, suffix, match_idx, hit_cnt}, {sr[3], e_cnt[1], e_cnt[0]});
      end
      if (i == 3) begin
        total++;
        if (compare_out[1:0] !== 2'b11 || match_idx[8:0] !== 9'd3 || suffix[1:0] !== 2'b10) begin
          bad++; $display("FAIL dual_both got c=%b i=%0d s=%b exp c=11 i=3 s=10", compare_out[1:0], match_idx[8:0], suffix[1:0]);
        end
      end
      if (i == 4) begin
        total++;
        if (out_valid !== 1'b1 || compare_out[1:0] !== 2'b00) begin
          bad++; $display("FAIL dual_invalid_entry got v=%b c=%b exp v=1 c=00", out_valid, compare_out[1:0]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k, seen;
    logic [NC*2-1:0] held;
    k = 0; seen = 0; held = '0;
    for (int t = 0; t < 16; t++) begin
      enable = !(t >= 4 && t <= 6);
      in_valid = (k < 8);
      case (k % 3)
        0: set_win(0, '0, '0, mk_win(pat_a, 8'h5A));
        1: set_win(0, '0, '0, mk_win(pat_b, 8'h11));
        default: set_win(0, 10'($urandom), 10'($urandom), mk_win(rnd_pat(), 8'($urandom)));
      endcase
      rnd_ch1();
      if (t == 4) held = compare_out;
      if (enable && in_valid) k++;
      tick();
      if (enable && out_valid) seen++;
      total++;
      if ({out_valid, compare_out, suffix, match_idx, hit_cnt} !== {sr[3], e_cnt[1], e_cnt[0]}) begin
        bad++; $display("FAIL b2b t%0d got=%h exp=%h", t, {out_valid, compare_out, suffix, match_idx, hit_cnt}, {sr[3], e_cnt[1], e_cnt[0]});
      end
      if (t >= 4 && t <= 6) begin
        total++;
        if (compare_out !== held || out_valid !== 1'b1) begin
          bad++; $display("FAIL b2b_hold t%0d got c=%b v=%b exp c=%b v=1", t, compare_out, out_valid, held);
        end
      end
    end
    enable = 1'b1; in_valid = 1'b0;
    total++;
    if (seen != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", seen); end
  endtask

  task automatic test_cfg_midstream();
    for (int t = 0; t < 8; t++) begin
      in_valid = (t <= 3);
      if (t < 2) set_win(0, '0, '0, mk_win(pat_a, 8'h5A));
      else set_win(0, '0, '0, mk_win(pat_b, 8'h11));
      rnd_ch1();
      if (t == 2) begin
        cfg_ch = 1'b0; cfg_sel = 1'b1; cfg_addr = 11'd9; cfg_wdata = {1'b1, 2'b11, pat_b};
        cfg_we = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL cfg_in_ready got=%b exp=0", in_ready); end
      end
      tick();
      cfg_we = 1'b0;
      total++;
      if ({out_valid, compare_out, suffix, match_idx, hit_cnt} !== {sr[3], e_cnt[1], e_cnt[0]}) begin
        bad++; $display("FAIL cfg t%0d got=%h exp=%h", t, {out_valid, compare_out, suffix, match_idx, hit_cnt}, {sr[3], e_cnt[1], e_cnt[0]});
      end
      if (t == 6) begin
        total++;
        if (out_valid !== 1'b1 || compare_out[1:0] !== 2'b01 || match_idx[8:0] !== 9'd9 || suffix[1:0] !== 2'b11) begin
          bad++; $display("FAIL cfg_new_entry got v=%b c=%b i=%0d s=%b exp v=1 c=01 i=9 s=11", out_valid, compare_out[1:0], match_idx[8:0], suffix[1:0]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturate();
    int guard;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    set_win(0, '0, '0, mk_win(pat_a, 8'h5A));
    in_valid = 1'b1;
    guard = 0;
    while (e_cnt[0] != 4'd14 && guard < 40) begin tick(); guard++; end
    total++;
    if (hit_cnt[3:0] !== 4'd14) begin bad++; $display("FAIL sat_preload got=%0d exp=14", hit_cnt[3:0]); end
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (hit_cnt[3:0] !== 4'hF) begin bad++; $display("FAIL sat_top got=%0d exp=15", hit_cnt[3:0]); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++;
    if (hit_cnt[3:0] !== 4'd0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL sat_clr_wins got=%0d v=%b exp=0 v=1", hit_cnt[3:0], out_valid);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({out_valid, compare_out, suffix, match_idx, hit_cnt} !== {sr[3], e_cnt[1], e_cnt[0]}) begin
        bad++; $display("FAIL sat_drain t%0d got=%h exp=%h", i, {out_valid, compare_out, suffix, match_idx, hit_cnt}, {sr[3], e_cnt[1], e_cnt[0]});
      end
    end
  endtask

  task automatic test_reset_midstream();
    set_win(0, '0, '0, mk_win(pat_a, 8'h5A));
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) sr[i] = '0;
    for (int c = 0; c < NC; c++) e_cnt[c] = '0;
    total++;
    if ({out_valid, compare_out, suffix, match_idx, hit_cnt} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs got=%h exp=0", {out_valid, compare_out, suffix, match_idx, hit_cnt});
    end
    in_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || hit_cnt !== '0) begin
        bad++; $display("FAIL rst_mid_quiet t%0d got v=%b cnt=%h exp v=0 cnt=0", i, out_valid, hit_cnt);
      end
    end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid = 1'b0;
      total++;
      if ({out_valid, compare_out, suffix, match_idx, hit_cnt} !== {sr[3], e_cnt[1], e_cnt[0]}) begin
        bad++; $display("FAIL rst_mid_lookup t%0d got=%h exp=%h", i, {out_valid, compare_out, suffix, match_idx, hit_cnt}, {sr[3], e_cnt[1], e_cnt[0]});
      end
    end
    total++;
    if (out_valid !== 1'b1 || compare_out[1:0] !== 2'b11 || match_idx[8:0] !== 9'd3) begin
      bad++; $display("FAIL rst_mid_tables got v=%b c=%b i=%0d exp v=1 c=11 i=3", out_valid, compare_out[1:0], match_idx[8:0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < NC; c++) begin
      for (int e = 0; e < 16; e++)
        cfg_write(c, 1'b1, e, {1'($urandom_range(0, 3) != 0), 2'($urandom), rnd_pat()});
      for (int j = 0; j < 64; j++)
        cfg_write(c, 1'b0, $urandom_range(0, 2047), $urandom_range(0, 15));
    end
    for (int t = 0; t < 300; t++) begin
      enable   = ($urandom_range(0, 4) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      cnt_clr  = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < NC; c++) begin
        logic [HW-1:0] p1, p2;
        logic [7:0] b;
        logic [PW-1:0] pat;
        int s;
        p1 = 10'($urandom); p2 = 10'($urandom); b = 8'($urandom);
        s = $urandom_range(0, 3);
        if (s == 0) pat = m_pat[c][m_idx[c][hash_m(int'(p1), int'(b))]];
        else if (s == 1) pat = m_pat[c][m_idx[c][1024 + hash_m(int'(p2), int'(b))]];
        else pat = rnd_pat();
        set_win(c, p1, p2, mk_win(pat, b));
      end
      tick();
      total++;
      if ({out_valid, compare_out, suffix, match_idx, hit_cnt} !== {sr[3], e_cnt[1], e_cnt[0]}) begin
        bad++; $display("FAIL random t%0d got=%h exp=%h", t, {out_valid, compare_out, suffix, match_idx, hit_cnt}, {sr[3], e_cnt[1], e_cnt[0]});
      end
    end
    enable = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      d_pre1[c] = '0; d_pre2[c] = '0; d_win[c] = '0; e_cnt[c] = '0;
    end
    for (int i = 0; i < 4; i++) sr[i] = '0;
    pat_a = rnd_pat();
    pat_b = rnd_pat();
    test_reset();
    clear_tables();
    test_basic();
    test_dual();
    test_back_to_back();
    test_cfg_midstream();
    test_saturate();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cuckoo_match_engine.md
Name: cuckoo_match_engine

Overview:
- Parametrised successor to the fixed-length, two-channel Cuckoo lookup stage in the payload engine.
- Each channel (case, nocase, ...) hashes the incoming payload window into two bucket-index tables (T1/T2), then reads two candidate pattern entries and compares them against the window.
- Adds valid tracking through the pipeline, stall-safe alignment of the compare window, runtime table programming, and per-channel saturating hit counters.
- Sits between the payload FIFO/pre-hash logic and the rule-match aggregator.

Parameters:
- PAT_BYTES, 14: pattern length in bytes; PAT_W = 8*PAT_BYTES.
- HASH_W, 10: pre-hash width and per-table index-table address width.
- IDX_W, 9: entry-table address width.
- SUFFIX_W, 2: suffix tag width.
- NUM_CH, 2: number of independent channels (ch0 = case, ch1 = nocase).
- WIN_W, 160: per-channel payload window width; constraint WIN_W >= PAT_W + 32.
- CNT_W, 32: hit counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  pipeline advance enable
- in_valid  in  1  window/pre-hash inputs valid
- in_ready  out  1  equals enable & ~cfg_we
- preHash_T1  in  NUM_CH*HASH_W  per-channel T1 pre-hash
- preHash_T2  in  NUM_CH*HASH_W  per-channel T2 pre-hash
- win_in  in  NUM_CH*WIN_W  per-channel payload window
- cfg_we  in  1  table write strobe
- cfg_ch  in  clog2(NUM_CH) (min 1)  target channel
- cfg_sel  in  1  0 = index table, 1 = entry table
- cfg_addr  in  HASH_W+1  index table: {T2sel, addr}; entry table: low IDX_W bits used
- cfg_wdata  in  PAT_W+SUFFIX_W+1  index table: low IDX_W bits used; entry table: {valid, suffix, pattern}
- out_valid  out  1  result valid
- compare_out  out  NUM_CH*2  per channel {B hit, A hit}
- suffix  out  NUM_CH*SUFFIX_W  suffix of the winning entry
- match_idx  out  NUM_CH*IDX_W  entry index of the winning entry
- cnt_clr  in  1  synchronous clear of the hit counters
- hit_cnt  out  NUM_CH*CNT_W  per-channel saturating hit count

Behaviour:
- Advance condition: adv = enable & ~cfg_we. When adv=0, every pipeline register, valid bit and output holds its value; memory read addresses are held so read data stays coherent.
- S1 (hash): on adv, per channel:
  - addr_T = (({pre[HASH_W-4:0],3'b000} + {3'b000,pre[HASH_W-1:3]} + win[7:0]) ^ pre), truncated to HASH_W, for T = T1, T2.
  - win[PAT_W+31:32] is captured into the window delay line; v1 <= in_valid.
- S2 (index read): synchronous read of the index table (depth 2^(HASH_W+1) x IDX_W). T1 uses address {0,addr_T1}; T2 uses {1,addr_T2}. v2 <= v1.
- S3 (entry read): synchronous read of the entry table (depth 2^IDX_W) at idxA = T1 data and idxB = T2 data. The window and indices are delayed to stay aligned. v3 <= v2.
- S4 (compare, registered):
  - hitA = entryA.valid & (entryA.pattern == window); hitB likewise.
  - compare_out = {hitB, hitA}.
  - suffix/match_idx come from A if hitA, else from B if hitB, else 0.
  - out_valid <= v3.
  - When v3=0, compare_out is forced to 0.
- Latency: exactly 4 adv cycles from an accepted input (in_valid & in_ready) to out_valid. Full throughput: 1 result per cycle.
- Config write:
  - Takes one cycle and stalls the pipeline that cycle.
  - Write-first is not required; a lookup never coincides with a write because of the stall.
  - Writes to a nonexistent channel (cfg_ch >= NUM_CH) are ignored.
- Counters:
  - On adv & out_valid & |compare_out[ch], hit_cnt[ch] increments and saturates at all-ones.
  - cnt_clr clears all counters; clear wins over a same-cycle increment.
- Reset (rst=0, asynchronous):
  - All pipeline registers, valids, outputs and counters go to 0; in_ready follows its combinational definition.
  - Table contents are NOT reset and persist.
  - Reset asserted mid-stream drops all in-flight results; no spurious out_valid after release.
- Address wrap: hash sums wrap modulo 2^HASH_W. No overflow flag.

Test Plan:
- Program ch0: index T1[0x05A]=3, entry[3]={1,2'b10,P}. Drive a window whose hash gives addr_T1=0x05A with bytes[143:32]=P -> 4 cycles later out_valid=1, compare_out[1:0]=2'b01, suffix=2'b10, match_idx=3, hit_cnt[0]=1.
- Both A and B entries match (idx 3 and 7) -> compare_out=2'b11, match_idx=3 (A priority); an entry with valid=0 and a matching pattern -> compare_out=0.
- Back-to-back stream of 8 inputs; enable low for 3 cycles mid-stream -> results in order with no loss or duplication; out_valid and outputs held during the stall.
- cfg_we pulse mid-stream -> in_ready=0 that cycle, pipeline frozen, the write lands, and the next lookup of that entry sees the new data.
- Preload hit_cnt to all-ones minus 1, then 3 hits -> saturates at all-ones; cnt_clr together with a hit -> counter 0.
- Assert rst low with 3 results in flight -> outputs and counters 0 immediately, no out_valid after release, table contents still readable via lookup.
